// File: rtl/fpaddsub_pkg.sv
// Shared constants for the FP add/sub rounding/packing stage.
// Rounding-mode encoding, default field widths and special-value patterns.
package fpaddsub_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rmode_e;

  // Patterns are built in 64 bits; callers size-cast to EXP_W+MAN_W+1.
  function automatic logic [63:0] infPattern(input logic sgn, input int expW, input int manW);
    logic [63:0] expOnes;
    expOnes = (64'd1 << expW) - 64'd1;
    return ({63'd0, sgn} << (expW + manW)) | (expOnes << manW);
  endfunction

  function automatic logic [63:0] maxFinitePattern(input logic sgn, input int expW, input int manW);
    logic [63:0] expMax;
    logic [63:0] manOnes;
    expMax  = (64'd1 << expW) - 64'd2;
    manOnes = (64'd1 << manW) - 64'd1;
    return ({63'd0, sgn} << (expW + manW)) | (expMax << manW) | manOnes;
  endfunction

endpackage

// File: rtl/fpaddsub_round_core.sv
// Combinational round-up decision and mantissa increment.
// mInc carries one extra bit so a mantissa carry-out is visible to the exponent logic.
module fpaddsub_round_core
  import fpaddsub_pkg::*;
#(
  parameter int MAN_W = DEF_MAN_W
) (
  input  rmode_e           rmode,
  input  logic             sgn,
  input  logic [MAN_W-1:0] m,
  input  logic             g,
  input  logic             r,
  input  logic             s,
  output logic             roundUp,
  output logic [MAN_W:0]   mInc
);

  logic inexact;

  assign inexact = g | r | s;

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves roundUp unassigned (no latch).
    roundUp = 1'b0;
    case (rmode)
      RM_RNE:  roundUp = g & (r | s | m[0]);
      RM_RTZ:  roundUp = 1'b0;
      RM_RUP:  roundUp = ~sgn & inexact;
      RM_RDN:  roundUp = sgn & inexact;
      default: roundUp = 1'b0;
    endcase
  end

  assign mInc = {1'b0, m} + {{MAN_W{1'b0}}, roundUp};

endmodule

// File: rtl/fpaddsub_round_pipe.sv
// Two-stage round-and-pack pipeline with valid/ready back-pressure.
// Stage 1 holds the normaliser outputs; stage 2 is the packed result register.
module fpaddsub_round_pipe
  import fpaddsub_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_zero_sum,
  input  logic                   in_sgn,
  input  logic [EXP_W:0]         in_norm_e,
  input  logic [MAN_W-1:0]       in_norm_m,
  input  logic                   in_g,
  input  logic                   in_r,
  input  logic                   in_s,
  input  logic                   in_sa,
  input  logic                   in_sb,
  input  logic                   in_ctrl,
  input  logic [1:0]             in_rmode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_z,
  output logic                   out_eof,
  output logic                   out_inexact
);

  localparam int W = EXP_W + MAN_W + 1;

  logic s1Valid, s2Valid;
  logic s1Adv, s2Adv;

  logic             s1Zero, s1Sgn, s1G, s1R, s1S, s1Sa, s1Sb, s1Ctrl;
  rmode_e           s1Rmode;
  logic [EXP_W:0]   s1NormE;
  logic [MAN_W-1:0] s1NormM;

  logic             resSgn;
  logic             roundUp;
  logic [MAN_W:0]   mInc;
  logic             carry;
  logic [MAN_W-1:0] manRnd;
  logic [EXP_W:0]   expAdj;
  logic             ovf;
  logic             toInf;
  logic [W-1:0]     zNext;
  logic             eofNext, inexNext;

  // in_ready depends combinationally on out_ready so a full pipe can shift in one cycle.
  assign s2Adv    = ~s2Valid | out_ready;
  assign s1Adv    = ~s1Valid | s2Adv;
  assign in_ready = s1Adv;
  assign out_valid = s2Valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      s1Valid     <= 1'b0;
      s2Valid     <= 1'b0;
      out_z       <= '0;
      out_eof     <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      if (s1Adv) s1Valid <= in_valid;
      if (s2Adv) s2Valid <= s1Valid;
      if (s2Adv && s1Valid) begin
        out_z       <= zNext;
        out_eof     <= eofNext;
        out_inexact <= inexNext;
      end
    end
  end

  // NOTE: stage-1 payload has no reset; s1Valid qualifies it, so only the valid bits need clearing.
  always_ff @(posedge clk) begin
    if (s1Adv && in_valid) begin
      s1Zero  <= in_zero_sum;
      s1Sgn   <= in_sgn;
      s1NormE <= in_norm_e;
      s1NormM <= in_norm_m;
      s1G     <= in_g;
      s1R     <= in_r;
      s1S     <= in_s;
      s1Sa    <= in_sa;
      s1Sb    <= in_sb;
      s1Ctrl  <= in_ctrl;
      s1Rmode <= rmode_e'(in_rmode);
    end
  end

  // An exact zero under effective subtraction is -0 only when rounding toward -inf.
  always_comb begin
    resSgn = s1Sgn;
    if (s1Zero) resSgn = (s1Sa ^ s1Sb ^ s1Ctrl) ? (s1Rmode == RM_RDN) : s1Sa;
  end

  fpaddsub_round_core #(
    .MAN_W (MAN_W)
  ) u_round_core (
    .rmode   (s1Rmode),
    .sgn     (resSgn),
    .m       (s1NormM),
    .g       (s1G),
    .r       (s1R),
    .s       (s1S),
    .roundUp (roundUp),
    .mInc    (mInc)
  );

  assign carry  = mInc[MAN_W];
  assign manRnd = carry ? '0 : mInc[MAN_W-1:0];
  assign expAdj = s1NormE + {{EXP_W{1'b0}}, carry};
  assign ovf    = expAdj[EXP_W] | (&expAdj[EXP_W-1:0]);
  assign toInf  = (s1Rmode == RM_RNE) |
                  ((s1Rmode == RM_RUP) & ~resSgn) |
                  ((s1Rmode == RM_RDN) & resSgn);

  always_comb begin
    zNext    = '0;
    eofNext  = 1'b0;
    inexNext = 1'b0;
    if (s1Zero) begin
      zNext = {resSgn, {(W-1){1'b0}}};
    end else begin
      inexNext = s1G | s1R | s1S;
      if (ovf) begin
        eofNext = 1'b1;
        zNext   = toInf ? W'(infPattern(resSgn, EXP_W, MAN_W))
                        : W'(maxFinitePattern(resSgn, EXP_W, MAN_W));
      end else begin
        zNext = {resSgn, expAdj[EXP_W-1:0], manRnd};
      end
    end
  end

endmodule
